// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings and defaults for the branch redirect / fetch PC controller.
// FSM state constants plus default PC width, refill length and counter width.
package branch_redirect_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam int DEF_PC_W          = 10;
    localparam int DEF_REFILL_CYCLES = 2;
    localparam int DEF_CNT_W         = 16;

    // Bubble counter only has to hold REFILL_CYCLES-1, at most 6.
    localparam int BUB_W = 3;

endpackage

// File: rtl/branch_redirect_ctrl_sat.sv
// Saturating up-counter with increment enable and async active-low clear.
// Ports: clk, rst_n (clear), inc (count one), count (sticks at all-ones).
module branch_redirect_ctrl_sat #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC controller: sequential fetch, branch redirect with flush and
// refill bubbles, halt; ports: stall/br_*/halt_req in, fetch_pc/en/flush/halted/taken_cnt out.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int              PC_W          = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter int              REFILL_CYCLES = DEF_REFILL_CYCLES,
    parameter int              CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt_req,
    output logic [PC_W-1:0]  fetch_pc,
    output logic             fetch_en,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(REFILL_CYCLES - 1);

    logic [1:0]       state;
    logic [BUB_W-1:0] bub;
    logic             redirect;
    logic             live;
    logic             cnt_inc;

    assign redirect = br_valid & branch_taken;
    assign live     = (state != ST_HALT);
    // A redirect that loses to a same-cycle halt is not counted.
    assign cnt_inc  = live & redirect & ~halt_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            fetch_en <= 1'b0;
            flush    <= 1'b0;
            halted   <= 1'b0;
            bub      <= '0;
        end else begin
            flush <= 1'b0;
            if (!live) begin
                fetch_en <= 1'b0;
            end else if (halt_req) begin
                // Younger stages still die if a branch resolved taken.
                state    <= ST_HALT;
                halted   <= 1'b1;
                fetch_en <= 1'b0;
                flush    <= redirect;
            end else if (redirect) begin
                state    <= ST_REFILL;
                fetch_pc <= branch_target;
                fetch_en <= 1'b0;
                flush    <= 1'b1;
                bub      <= BUB_LOAD;
            end else if (state == ST_REFILL) begin
                if (bub == '0) begin
                    state    <= ST_RUN;
                    fetch_en <= 1'b1;
                end else begin
                    bub <= bub - BUB_W'(1);
                end
            end else begin
                state    <= ST_RUN;
                fetch_en <= 1'b1;
                // Advance only past a PC that was actually fetched.
                if (fetch_en && !stall) begin
                    fetch_pc <= fetch_pc + PC_W'(1);
                end
            end
        end
    end

    branch_redirect_ctrl_sat #(
        .W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .count (taken_cnt)
    );

endmodule
